// File: rtl/data_memory_ctrl.sv
// Byte-wide data memory shared between a host loader and a processor DRAM port.
// Host and processor reads return registered data one cycle after the strobe; writes land on the sampling edge.
module data_memory_ctrl #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  output logic              proc_enable,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [7:0]        proc_wdata,
  output logic [7:0]        proc_rdata,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic              proc_finish,
  output logic              done,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [31:0]       run_cycles
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [7:0] mem_q [DEPTH];

  logic [1:0]  state_q, state_d;
  logic        err_q, err_d;
  logic [7:0]  proc_rdata_q, proc_rdata_d;
  logic [7:0]  host_rdata_q, host_rdata_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] run_cyc_q, run_cyc_d;

  logic in_run, host_own, host_ok, proc_ok;
  logic host_wr_do, host_rd_do, proc_wr_do, proc_wr_svc, proc_rd_do, run_clear;
  logic mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [7:0] mem_wdat;
  logic [7:0] host_mem_dat, proc_mem_dat;

  assign in_run   = (state_q == ST_RUN);
  assign host_own = !in_run;
  assign host_ok  = ({1'b0, host_addr} < DEPTH_LIM);
  assign proc_ok  = ({1'b0, proc_addr} < DEPTH_LIM);

  // Out-of-range accesses are still serviced (counted, rvalid pulsed) but read as zero and never write.
  assign host_wr_do  = host_own && host_wr && host_ok;
  assign host_rd_do  = host_own && host_rd && !host_wr;
  assign proc_wr_svc = in_run && proc_write;
  assign proc_wr_do  = proc_wr_svc && proc_ok;
  assign proc_rd_do  = in_run && proc_read && !proc_write;
  assign run_clear   = (state_q == ST_LOAD) && start;

  assign host_mem_dat = host_ok ? mem_q[host_addr[IDX_W-1:0]] : 8'h00;
  assign proc_mem_dat = proc_ok ? mem_q[proc_addr[IDX_W-1:0]] : 8'h00;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (start)       state_d = ST_RUN;
      ST_RUN:  if (proc_finish) state_d = ST_DONE;
      ST_DONE: if (start)       state_d = ST_LOAD;
      default:                  state_d = ST_LOAD;
    endcase

    err_d = run_clear ? 1'b0 : err_q;
    if (in_run && (host_wr || host_rd)) err_d = 1'b1;
    if (host_own && (host_wr || host_rd) && !host_ok) err_d = 1'b1;
    if (in_run && (proc_read || proc_write) && !proc_ok) err_d = 1'b1;
    if (in_run && proc_read && proc_write) err_d = 1'b1;

    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    run_cyc_d = run_cyc_q;
    if (run_clear) begin
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      run_cyc_d = '0;
    end else begin
      if (proc_rd_do && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      if (proc_wr_svc && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      if (in_run && run_cyc_q != 32'hFFFF_FFFF) run_cyc_d = run_cyc_q + 32'd1;
    end

    proc_rdata_d  = proc_rd_do ? proc_mem_dat : proc_rdata_q;
    host_rdata_d  = host_rd_do ? host_mem_dat : host_rdata_q;
    host_rvalid_d = host_rd_do;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      err_q         <= 1'b0;
      proc_rdata_q  <= 8'h00;
      host_rdata_q  <= 8'h00;
      host_rvalid_q <= 1'b0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      run_cyc_q     <= '0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      proc_rdata_q  <= proc_rdata_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      run_cyc_q     <= run_cyc_d;
    end
  end

  // Ownership makes host and processor writes mutually exclusive, so one write port suffices.
  assign mem_we   = !reset && (host_wr_do || proc_wr_do);
  assign mem_idx  = host_wr_do ? host_addr[IDX_W-1:0] : proc_addr[IDX_W-1:0];
  assign mem_wdat = host_wr_do ? host_wdata : proc_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdat;
  end

  assign proc_enable = in_run;
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;
  assign proc_rdata  = proc_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign run_cycles  = run_cyc_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Vector table plus host read-back scoreboard for data_memory_ctrl.
module tb_data_memory_ctrl;

  localparam int OP_IDLE = 0, OP_HWR = 1, OP_HRD = 2, OP_HWRD = 3, OP_PRD = 4, OP_PWR = 5;
  localparam int OP_PRW = 6, OP_START = 7, OP_FIN = 8, OP_FINW = 9, OP_RSTW = 10;

  typedef struct {
    int          op;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        en, dn, er;
    logic [7:0]  pr;
    logic [15:0] rc, wc;
    logic [31:0] cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, host_wr, host_rd;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        host_rvalid, proc_enable;
  logic [15:0] proc_addr;
  logic [7:0]  proc_wdata, proc_rdata;
  logic        proc_read, proc_write, proc_finish, done, err;
  logic [15:0] rd_count, wr_count;
  logic [31:0] run_cycles;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  vec_t vecs[$];

  data_memory_ctrl #(.DEPTH(4096), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .proc_enable(proc_enable),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_read(proc_read), .proc_write(proc_write), .proc_finish(proc_finish),
    .done(done), .err(err), .rd_count(rd_count), .wr_count(wr_count), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int op, input int addr, input int dat, input int en, input int dn,
                              input int er, input int pr, input int rc, input int wc, input int cyc);
    vec_t v;
    v.op = op; v.addr = addr[15:0]; v.dat = dat[7:0];
    v.en = en[0]; v.dn = dn[0]; v.er = er[0]; v.pr = pr[7:0];
    v.rc = rc[15:0]; v.wc = wc[15:0]; v.cyc = cyc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = 1'b0; start = 1'b0; host_wr = 1'b0; host_rd = 1'b0;
    proc_read = 1'b0; proc_write = 1'b0; proc_finish = 1'b0;
    host_addr = v.addr; host_wdata = v.dat; proc_addr = v.addr; proc_wdata = v.dat;
    case (v.op)
      OP_HWR:   host_wr = 1'b1;
      OP_HRD:   begin host_rd = 1'b1; sb.push_back(v.dat); end
      OP_HWRD:  begin host_wr = 1'b1; host_rd = 1'b1; end
      OP_PRD:   proc_read = 1'b1;
      OP_PWR:   proc_write = 1'b1;
      OP_PRW:   begin proc_read = 1'b1; proc_write = 1'b1; end
      OP_START: start = 1'b1;
      OP_FIN:   proc_finish = 1'b1;
      OP_FINW:  begin proc_finish = 1'b1; proc_write = 1'b1; end
      OP_RSTW:  begin reset = 1'b1; proc_write = 1'b1; end
      default:  ;
    endcase
  endtask

  // Host read-back data is checked here whenever the DUT flags it valid.
  always @(posedge clk) begin
    #2;
    if (host_rvalid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected_rvalid: got rvalid with data 0x%0h, want no read pending", host_rdata);
      end else begin
        chk("sb_host_rdata", 32'(host_rdata), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; host_wr = 1'b0; host_rd = 1'b0; host_addr = '0; host_wdata = '0;
    proc_addr = '0; proc_wdata = '0; proc_read = 1'b0; proc_write = 1'b0; proc_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_hrdata", 32'(host_rdata), 0);
    chk("rst_prdata", 32'(proc_rdata), 0);
    chk("rst_enable", 32'(proc_enable), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);

    //          op        addr     dat    en dn er pr     rc wc cyc
    vecs.push_back(mk(OP_IDLE,  0,       0,     0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HWR,   'h0010, 'hA5,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HWR,   'h0FFF, 'h3C,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HRD,   'h0010, 'hA5,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HRD,   'h0FFF, 'h3C,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HWR,   'h0020, 'h77,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HWR,   'h0005, 'h55,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HWR,   'h0234, 'h5A,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HWR,   'h0009, 'h09,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_PWR,   'h0030, 'hAB,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HWRD,  'h0040, 'h12,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_START, 0,       0,     1, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_PRD,   'h0020, 0,     1, 0, 0, 'h77, 1, 0, 1));
    vecs.push_back(mk(OP_PWR,   'h0021, 'h99,  1, 0, 0, 'h77, 1, 1, 2));
    vecs.push_back(mk(OP_FIN,   0,       0,     0, 1, 0, 'h77, 1, 1, 3));
    vecs.push_back(mk(OP_HRD,   'h0021, 'h99,  0, 1, 0, 'h77, 1, 1, 3));
    vecs.push_back(mk(OP_START, 0,       0,     0, 0, 0, 'h77, 1, 1, 3));
    vecs.push_back(mk(OP_START, 0,       0,     1, 0, 0, 'h77, 0, 0, 0));
    vecs.push_back(mk(OP_PRD,   'h1000, 0,     1, 0, 1, 0,     1, 0, 1));
    vecs.push_back(mk(OP_PRD,   'h0020, 0,     1, 0, 1, 'h77, 2, 0, 2));
    vecs.push_back(mk(OP_PWR,   'h1234, 'hEE,  1, 0, 1, 'h77, 2, 1, 3));
    vecs.push_back(mk(OP_PRW,   'h0005, 'h11,  1, 0, 1, 'h77, 2, 2, 4));
    vecs.push_back(mk(OP_HWR,   'h0040, 'hFF,  1, 0, 1, 'h77, 2, 2, 5));
    vecs.push_back(mk(OP_FINW,  'h0006, 'h66,  0, 1, 1, 'h77, 2, 3, 6));
    vecs.push_back(mk(OP_PWR,   'h0007, 'h07,  0, 1, 1, 'h77, 2, 3, 6));
    vecs.push_back(mk(OP_HRD,   'h0005, 'h11,  0, 1, 1, 'h77, 2, 3, 6));
    vecs.push_back(mk(OP_HRD,   'h0234, 'h5A,  0, 1, 1, 'h77, 2, 3, 6));
    vecs.push_back(mk(OP_HRD,   'h0040, 'h12,  0, 1, 1, 'h77, 2, 3, 6));
    vecs.push_back(mk(OP_HRD,   'h0006, 'h66,  0, 1, 1, 'h77, 2, 3, 6));
    vecs.push_back(mk(OP_HRD,   'h1234, 'h00,  0, 1, 1, 'h77, 2, 3, 6));
    vecs.push_back(mk(OP_START, 0,       0,     0, 0, 1, 'h77, 2, 3, 6));
    vecs.push_back(mk(OP_START, 0,       0,     1, 0, 0, 'h77, 0, 0, 0));
    vecs.push_back(mk(OP_HWR,   'h0041, 'hCC,  1, 0, 1, 'h77, 0, 0, 1));
    vecs.push_back(mk(OP_PWR,   'h0008, 'h88,  1, 0, 1, 'h77, 0, 1, 2));
    vecs.push_back(mk(OP_RSTW,  'h0009, 'h99,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HRD,   'h0009, 'h09,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_HRD,   'h0010, 'hA5,  0, 0, 0, 0,     0, 0, 0));
    vecs.push_back(mk(OP_IDLE,  0,       0,     0, 0, 0, 0,     0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_enable", i), 32'(proc_enable), 32'(vecs[i].en));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].er));
      chk($sformatf("v%0d_prdata", i), 32'(proc_rdata), 32'(vecs[i].pr));
      chk($sformatf("v%0d_rd_count", i), 32'(rd_count), 32'(vecs[i].rc));
      chk($sformatf("v%0d_wr_count", i), 32'(wr_count), 32'(vecs[i].wc));
      chk($sformatf("v%0d_run_cycles", i), run_cycles, vecs[i].cyc);
      chk($sformatf("v%0d_rvalid", i), 32'(host_rvalid), (vecs[i].op == OP_HRD) ? 32'd1 : 32'd0);
    end

    // Long run of back-to-back reads drives rd_count into saturation.
    drive(mk(OP_START, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    start = 1'b0;
    proc_read = 1'b1;
    proc_addr = 16'h0020;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      #1;
      if (i == 65533) chk("sat_rd_count_fffe", 32'(rd_count), 32'h0000_FFFE);
      if (i == 65534) chk("sat_rd_count_ffff", 32'(rd_count), 32'h0000_FFFF);
    end
    proc_read = 1'b0;
    proc_finish = 1'b1;
    @(posedge clk);
    #1;
    proc_finish = 1'b0;
    chk("sat_rd_count_final", 32'(rd_count), 32'h0000_FFFF);
    chk("sat_run_cycles", run_cycles, 32'd65541);
    chk("sat_wr_count", 32'(wr_count), 0);
    chk("sat_done", 32'(done), 1);
    chk("sat_enable", 32'(proc_enable), 0);
    chk("sat_err", 32'(err), 0);
    chk("sat_prdata", 32'(proc_rdata), 32'h77);
    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Byte-wide data-memory responder on the far side of the processor's DRAM port: `addr_out`, `dout`, `read`, `write`, `finish`. Before a run, a host preloads the memory, for example with an image. The controller then releases the processor via `enable` and services its reads and writes. Once the processor raises `finish`, the host can read back the down-sampled result.

## Interface
- `DEPTH`, default 4096: number of bytes in the memory; valid addresses are 0..DEPTH-1.
- `ADDR_W`, default 16: address width on both ports.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: host request to begin a run; honoured only in LOAD.
- `host_wr`  in  1: host write strobe.
- `host_rd`  in  1: host read strobe.
- `host_addr`  in  ADDR_W: host byte address.
- `host_wdata`  in  8: host write data.
- `host_rdata`  out  8: host read data.
- `host_rvalid`  out  1: one-cycle pulse marking `host_rdata` as valid.
- `proc_enable`  out  1: drives the processor `enable` input.
- `proc_addr`  in  ADDR_W: from the processor `addr_out`.
- `proc_wdata`  in  8: from the processor `dout`.
- `proc_rdata`  out  8: to the processor `din`.
- `proc_read`  in  1: processor read strobe.
- `proc_write`  in  1: processor write strobe.
- `proc_finish`  in  1: processor finish flag.
- `done`  out  1: high in DONE.
- `err`  out  1: sticky protocol/range error.
- `rd_count`  out  16: processor reads serviced; saturates at 0xFFFF.
- `wr_count`  out  16: processor writes serviced; saturates at 0xFFFF.
- `run_cycles`  out  32: clock cycles spent in RUN; saturates.

## Operation
States:
- **LOAD**: host owns the memory and `proc_enable`=0. `start`=1 clears the counters and `err` and moves to RUN.
- **RUN**: processor owns the memory and `proc_enable`=1. `proc_finish`=1 moves to DONE.
- **DONE**: host owns the memory (read-back) and `proc_enable`=0. `start`=1 returns to LOAD; `err` and the counters are held until the next run starts.

Host port:
- `host_wr` writes `host_wdata` to `host_addr`.
- `host_rd` reads `host_addr`.
- `host_wr` and `host_rd` together: the write wins, no read occurs and `host_rvalid` stays 0.
- Host strobes in RUN are ignored and set `err`.

Processor port, honoured only in RUN (strobes in other states are ignored, with no `err`):
- `proc_write` stores `proc_wdata` at `proc_addr` and increments `wr_count`.
- `proc_read` loads `mem[proc_addr]` into the `proc_rdata` register and increments `rd_count`.
- `proc_read` and `proc_write` together: the write is performed, the read is dropped, `proc_rdata` holds its value and `err` is set.

Range rule: any address >= DEPTH, on either port:
- writes are discarded;
- reads return 0x00;
- `err` is set.

Memory contents survive `reset`; there is no clear.

## Timing
- Reset values: state LOAD, `proc_enable`=0, `done`=0, `err`=0, `proc_rdata`=0x00, `host_rdata`=0x00, `host_rvalid`=0, all counters 0.
- Processor read latency is 1 cycle. The edge that samples `proc_read`=1 updates `proc_rdata`, which is then held until the next serviced read. The processor keeps `read` asserted for at least two cycles and has MDR sample on the second.
- Processor write takes effect on the sampling edge. A read of the same address issued the next cycle returns the new data.
- Host read: `host_rdata` and `host_rvalid`=1 appear one cycle after `host_rd` is sampled.
- `proc_enable` rises on the edge after `start` is sampled in LOAD. It falls on the edge that samples `proc_finish`=1.
- In the finish cycle itself, a processor write is still performed.
- `run_cycles` increments on every edge while in RUN, including the edge that leaves RUN.
- `reset` mid-RUN: on the next edge the state returns to LOAD and `proc_enable` drops. Any strobe sampled on that edge is not performed.
- `start` in RUN or DONE-to-LOAD: no effect on memory.

## Test plan
- **Load and read-back, no run**: reset, host writes 0xA5→0x0010 and 0x3C→0x0FFF, then host reads both. Required: `host_rvalid` pulses one cycle after each read, with data 0xA5 then 0x3C.
- **Processor read/write**:
  - Preload 0x0020=0x77, then `start`; `proc_enable`=1 from the next cycle.
  - Processor read 0x0020: `proc_rdata`=0x77 one cycle later.
  - Processor write 0x99→0x0021.
  - `proc_finish`: `done`=1, `proc_enable`=0, `rd_count`=1, `wr_count`=1.
  - Host read 0x0021: returns 0x99.
- **Range and collisions**:
  - Processor read of 0x1000 with DEPTH=4096: returns 0x00 and sets `err`.
  - Processor write of 0x1234: memory unchanged.
  - `proc_read` and `proc_write` together on 0x0005 with data 0x11: `mem[5]`=0x11, `proc_rdata` unchanged, `err`=1.
  - Next `start` from LOAD clears `err`.
- **Ownership**: host write in RUN sets `err` and leaves memory unchanged. Processor write while in LOAD or DONE is ignored, `wr_count` stays 0 and `err` is unaffected.
- **Reset mid-run**:
  - Issue `reset` with `proc_write` asserted in RUN: the write is not performed, state is LOAD, `proc_enable`=0 and counters are 0.
  - Previously loaded bytes are still readable by the host.
- **Saturation**: 65,540 processor reads in one run leave `rd_count` at 0xFFFF, and `run_cycles` equals the number of edges spent in RUN.
